// File: rtl/snoop_pkg.sv
// snoop_pkg: opcodes, FSM encoding and snoop-port constants shared by snoop_loader.
// SNOOP_LOADER_CHECKSUM_EN adds the WCSUM state that follows the WRITE data.
package snoop_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] CMD_HALT  = 8'h04;
  localparam logic SNOOPM_WRITE = 1'b0;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RUN,
    ST_GET_ADDR,
    ST_GET_CNT,
    ST_WDATA,
`ifdef SNOOP_LOADER_CHECKSUM_EN
    ST_WCSUM,
`endif
    ST_RADDR,
    ST_RWAIT,
    ST_RSEND
  } state_t;
`ifdef SNOOP_LOADER_CHECKSUM_EN
  localparam state_t ST_WR_DONE = ST_WCSUM;
`else
  localparam state_t ST_WR_DONE = ST_IDLE;
`endif
  function automatic logic rd_phase(input state_t s);
    return s inside {ST_RADDR, ST_RWAIT, ST_RSEND};
  endfunction
endpackage

// File: rtl/snoop_rd_skid.sv
// snoop_rd_skid: one-entry holding register presenting the readback byte with out_valid/out_ready.
module snoop_rd_skid (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data
);
  logic       r_valid;
  logic [7:0] r_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/snoop_loader.sv
// snoop_loader: byte-serial host loader/monitor that halts, loads, reads back and releases the discus core.
// Define SNOOP_LOADER_CHECKSUM_EN to require a modulo-256 checksum byte after every WRITE.
module snoop_loader
  import snoop_pkg::*;
#(
  parameter int ERR_STICKY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  input  logic [7:0] snoopq,
  output logic       snoopm,
  output logic       snoopp,
  output logic       cpu_reset,
  output logic       busy,
  output logic       err
);
  state_t     r_state;
  logic [7:0] r_addr;
  logic [7:0] r_rem;
  logic [7:0] r_snoopa;
  logic [7:0] r_snoopd;
  logic       r_is_read;
  logic       r_snoopm;
  logic       r_snoopp;
  logic       r_cpu_reset;
  logic       r_err;
  logic       w_fire;
  logic       w_load;
  logic       w_take;
  logic       w_csum_bad;
  assign w_fire    = in_valid & in_ready;
  assign w_load    = r_state == ST_RWAIT;
  assign w_take    = (r_state == ST_RSEND) & out_valid & out_ready;
  assign in_ready  = reset & ~rd_phase(r_state);
  assign busy      = ~(r_state inside {ST_IDLE, ST_RUN});
  assign snoopa    = r_snoopa;
  assign snoopd    = r_snoopd;
  assign snoopm    = r_snoopm;
  assign snoopp    = r_snoopp;
  assign cpu_reset = r_cpu_reset;
  assign err       = r_err;
`ifdef SNOOP_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_csum <= '0;
    else if (w_fire && r_state == ST_GET_ADDR)
      r_csum <= in_data;
    else if (w_fire && (r_state == ST_GET_CNT || r_state == ST_WDATA))
      r_csum <= r_csum + in_data;
  end
  assign w_csum_bad = w_fire && r_state == ST_WCSUM && in_data != r_csum;
`else
  assign w_csum_bad = 1'b0;
`endif
  // r_rem holds transfers left minus one, so a count byte of 0 yields 256 transfers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_snoopa    <= '0;
      r_snoopd    <= '0;
      r_is_read   <= 1'b0;
      r_snoopm    <= ~SNOOPM_WRITE;
      r_snoopp    <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_snoopm <= ~SNOOPM_WRITE;
      r_err    <= ((ERR_STICKY != 0) & r_err) | w_csum_bad;
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_fire) begin
            if (in_data == CMD_WRITE || in_data == CMD_READ) begin
              r_is_read   <= in_data == CMD_READ;
              r_snoopp    <= 1'b1;
              r_cpu_reset <= 1'b1;
              r_state     <= ST_GET_ADDR;
            end else if (in_data == CMD_RUN) begin
              r_snoopp    <= 1'b0;
              r_cpu_reset <= 1'b0;
              r_state     <= ST_RUN;
            end else if (in_data == CMD_HALT) begin
              r_snoopp    <= 1'b1;
              r_cpu_reset <= 1'b1;
              r_err       <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_GET_ADDR: begin
          if (w_fire) begin
            r_addr  <= in_data;
            r_state <= ST_GET_CNT;
          end
        end
        ST_GET_CNT: begin
          if (w_fire) begin
            r_rem    <= in_data - 8'd1;
            r_snoopa <= r_addr;
            r_state  <= r_is_read ? ST_RADDR : ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_fire) begin
            r_snoopa <= r_addr;
            r_snoopd <= in_data;
            r_snoopm <= SNOOPM_WRITE;
            r_addr   <= r_addr + 8'd1;
            r_rem    <= r_rem - 8'd1;
            r_state  <= (r_rem == 8'd0) ? ST_WR_DONE : ST_WDATA;
          end
        end
`ifdef SNOOP_LOADER_CHECKSUM_EN
        ST_WCSUM: begin
          if (w_fire)
            r_state <= ST_IDLE;
        end
`endif
        ST_RADDR: r_state <= ST_RWAIT;
        ST_RWAIT: r_state <= ST_RSEND;
        ST_RSEND: begin
          if (w_take) begin
            r_addr   <= r_addr + 8'd1;
            r_rem    <= r_rem - 8'd1;
            r_snoopa <= r_addr + 8'd1;
            r_state  <= (r_rem == 8'd0) ? ST_IDLE : ST_RADDR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  snoop_rd_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (snoopq),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data)
  );
endmodule

// File: tb/tb_snoop_loader.sv
// tb_snoop_loader: randomized bench for snoop_loader checked against a memory-level reference model.
module tb_snoop_loader;
  import snoop_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] snoopa, snoopd, snoopq;
  logic       snoopm, snoopp, cpu_reset, busy, err;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       exp_err = 1'b0;
  int         checks = 0;
  int         errors = 0;

  snoop_loader dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .snoopa(snoopa), .snoopd(snoopd), .snoopq(snoopq), .snoopm(snoopm),
    .snoopp(snoopp), .cpu_reset(cpu_reset), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // discus memory as seen through the snoop port
  always @(posedge clk) begin
    if (snoopm == SNOOPM_WRITE) mem[snoopa] <= snoopd;
    snoopq <= mem[snoopa];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_snoopp"}, snoopp, 1);
    check({tag, "_cpu_reset"}, cpu_reset, 1);
    check({tag, "_snoopm"}, snoopm, 1);
    check({tag, "_snoopa"}, snoopa, 0);
    check({tag, "_snoopd"}, snoopd, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("send_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d[$], input bit bad);
    int n;
    logic [7:0] s, ad;
    n = (c == 8'd0) ? 256 : int'(c);
    send_byte(CMD_WRITE);
    check("wr_halt", {snoopp, cpu_reset}, 2'b11);
    send_byte(a);
    check("wr_busy", busy, 1);
    send_byte(c);
    check("wr_nowrite", snoopm, 1);
    s = a + c;
    for (int i = 0; i < n; i++) begin
      ad = a + 8'(i);
      send_byte(d[i]);
      check("wr_m", snoopm, SNOOPM_WRITE);
      check("wr_a", snoopa, ad);
      check("wr_d", snoopd, d[i]);
      ref_mem[ad] = d[i];
      s = s + d[i];
    end
`ifdef SNOOP_LOADER_CHECKSUM_EN
    check("wr_csum_busy", busy, 1);
    send_byte(bad ? 8'h00 : s);
    exp_err = exp_err | bad;
    check("wr_csum_err", err, exp_err);
`else
    check("wr_err", err, exp_err | bad);
`endif
    check("wr_idle", busy, 0);
    @(negedge clk);
    check("wr_m_end", snoopm, 1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] c, input int hold2);
    int n, w, h;
    logic [7:0] ad;
    n = (c == 8'd0) ? 256 : int'(c);
    send_byte(CMD_READ);
    check("rd_halt", {snoopp, cpu_reset}, 2'b11);
    send_byte(a);
    send_byte(c);
    for (int i = 0; i < n; i++) begin
      ad = a + 8'(i);
      w = 0;
      while (!out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("rd_valid", out_valid, 1);
      check("rd_data", out_data, ref_mem[ad]);
      check("rd_addr", snoopa, ad);
      check("rd_in_ready", in_ready, 0);
      h = (hold2 < 0) ? int'($urandom_range(0, 3)) : ((i == 1) ? hold2 : 0);
      repeat (h) begin
        @(negedge clk);
        check("rd_hold_v", out_valid, 1);
        check("rd_hold_d", out_data, ref_mem[ad]);
        check("rd_hold_a", snoopa, ad);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check("rd_done_busy", busy, 0);
    check("rd_done_valid", out_valid, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b1;
    #1;
    check("por_in_ready", in_ready, 1);
    q = '{8'h03, 8'h20, 8'h60, 8'h06, 8'h20, 8'h60, 8'h09, 8'h20, 8'h60, 8'h60};
    do_write(8'h00, 8'h0A, q, 1'b0);
    do_read(8'h00, 8'h03, 5);
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    do_write(8'h10, 8'h00, q, 1'b0);
    q = '{8'hAA, 8'hBB, 8'hCC};
    do_write(8'hFE, 8'h03, q, 1'b0);
    do_read(8'hFE, 8'h03, -1);
    send_byte(CMD_RUN);
    check("run_p", snoopp, 0);
    check("run_r", cpu_reset, 0);
    check("run_busy", busy, 0);
    send_byte(8'h7F);
    exp_err = 1'b1;
    check("run_bad_err", err, 1);
    check("run_bad_stays", cpu_reset, 0);
    do_read(8'h05, 8'h01, -1);
    check("rd_stays_halted", {snoopp, cpu_reset}, 2'b11);
    check("err_sticky", err, 1);
    send_byte(CMD_HALT);
    exp_err = 1'b0;
    check("halt_err_clr", err, 0);
    send_byte(8'h7F);
    exp_err = 1'b1;
    check("bad_err", err, 1);
    check("bad_nowrite", snoopm, 1);
    check("bad_busy", busy, 0);
    @(negedge clk);
    check("bad_sticky", err, 1);
    send_byte(CMD_HALT);
    exp_err = 1'b0;
    check("halt_clr", err, 0);
`ifdef SNOOP_LOADER_CHECKSUM_EN
    q = '{8'h55};
    do_write(8'h00, 8'h01, q, 1'b1);
    send_byte(CMD_HALT);
    exp_err = 1'b0;
    check("csum_halt_clr", err, 0);
`endif
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: begin
          q = {};
          b = 8'($urandom_range(1, 6));
          for (int i = 0; i < int'(b); i++) q.push_back(8'($urandom));
          do_write(8'($urandom), b, q, 1'b0);
        end
        1: do_read(8'($urandom), 8'($urandom_range(1, 5)), -1);
        2: begin
          send_byte(CMD_RUN);
          check("rnd_run", {snoopp, cpu_reset}, 2'b00);
        end
        3: begin
          send_byte(CMD_HALT);
          exp_err = 1'b0;
          check("rnd_halt", {snoopp, cpu_reset, err}, 3'b110);
        end
        default: begin
          send_byte(8'($urandom_range(5, 255)));
          exp_err = 1'b1;
          check("rnd_bad", err, 1);
        end
      endcase
    end
    send_byte(CMD_WRITE);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(8'hAA);
    check("mid_wr_d", snoopd, 8'hAA);
    ref_mem[0] = 8'hAA;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset("mid");
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_in_ready", in_ready, 1);
    send_byte(CMD_HALT);
    check("mid_halt_busy", busy, 0);
    check("mid_halt_nowrite", snoopm, 1);
    check("mid_halt_p", snoopp, 1);
    do_read(8'h00, 8'h01, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snoop_loader.md
Name: snoop_loader

Overview:
- Host-side program loader and monitor placed directly upstream of the discus core's snoop port.
- Consumes a byte-serial command stream (valid/ready) from a host link such as a UART receiver.
- Uses it to halt the core, write or read back its 8-bit memory through snoopa/snoopd/snoopq/snoopm/snoopp, and release it to run.
- Replaces the hand-driven load sequence used in simulation with synthesizable control.

Parameters:
- ERR_STICKY, 1, 1: err stays high until the next HALT command; 0: err is a one-cycle pulse.

Ports:
- clk  in  1  system clock; also feeds discus clk and snoop_clk
- reset  in  1  asynchronous, active-low reset
- in_data  in  8  command/data byte from host
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- out_data  out  8  readback byte to host
- out_valid  out  1  out_data valid
- out_ready  in  1  host accepts out_data
- snoopa  out  8  snoop address to discus
- snoopd  out  8  snoop write data to discus
- snoopq  in  8  snoop read data from discus, registered, valid one clk after snoopa
- snoopm  out  1  0 = write snoopd to snoopa this clk; 1 = read/no write
- snoopp  out  1  1 = core halted, snoop port owns memory
- cpu_reset  out  1  active-high reset to discus core
- busy  out  1  FSM not in IDLE/RUN
- err  out  1  protocol error flag

Behaviour:
- Reset values:
  - snoopp=1, cpu_reset=1, snoopm=1, snoopa=0, snoopd=0
  - out_valid=0, out_data=0, err=0, busy=0
  - in_ready=0 while reset is asserted; 1 in the first cycle after reset deasserts
  - FSM=IDLE
- A byte transfers when in_valid & in_ready.
- Commands (first byte in IDLE or RUN):
  - 0x01 WRITE: then addr, count, then count data bytes.
  - 0x02 READ: then addr, count.
  - 0x03 RUN: snoopp=0, cpu_reset=0 from the next cycle; FSM=RUN.
  - 0x04 HALT: snoopp=1, cpu_reset=1 from the next cycle; clears sticky err; FSM=IDLE.
  - Any other byte: err set; byte consumed; FSM unchanged.
- Count rules: count 0 means 256. The address increments mod 256 after every access, so 0xFF wraps to 0x00.
- WRITE or READ received in RUN implicitly halts first: snoopp=1 and cpu_reset=1 in the cycle after the command byte. The core stays halted afterwards.
- FSM states: IDLE, RUN, GET_ADDR, GET_CNT, WDATA, [WCSUM], RADDR, RWAIT, RSEND.
- WDATA:
  - Each accepted byte produces exactly one write cycle in the following cycle: snoopa=addr, snoopd=byte, snoopm=0.
  - snoopm is 1 in every other cycle.
  - Writes are back-to-back if bytes arrive every cycle (throughput 1 byte/clk).
  - After the last byte, go to IDLE.
- READ, per byte:
  - RADDR drives snoopa=addr, snoopm=1.
  - RWAIT captures snoopq into out_data and sets out_valid=1.
  - RSEND holds out_data/out_valid stable until out_ready, then increments addr and goes to RADDR, or to IDLE when count is exhausted.
  - snoopa is frozen during backpressure.
  - in_ready=0 throughout READ data phases.
- in_ready=0 in RADDR/RWAIT/RSEND. Otherwise in_ready=1.
- Mid-operation reset: everything returns to reset values immediately. Partially transferred commands are discarded, and the next byte is parsed as a command.
- No command is ever interpreted during GET_ADDR/GET_CNT/WDATA: every byte there is an operand.

Optional Feature:
- SNOOP_LOADER_CHECKSUM_EN:
  - When defined, a WRITE is followed by one extra checksum byte, received in state WCSUM.
  - The checksum equals the 8-bit modulo-256 sum of the addr, count and data bytes.
  - On mismatch, err is set; already-written memory is not rolled back.
  - When undefined, no checksum byte is expected and WCSUM does not exist.

Decomposition:
- Shared package snoop_pkg holds:
  - command opcode constants (CMD_WRITE=8'h01, CMD_READ=8'h02, CMD_RUN=8'h03, CMD_HALT=8'h04)
  - the FSM state encoding
  - SNOOPM_WRITE=1'b0
- One natural sub-module: snoop_rd_skid, a one-entry output holding register implementing out_valid/out_ready for the readback path.

Test Plan:
- Load: stream 01 00 0A 03 20 60 06 20 60 09 20 60 60 → ten write cycles with snoopm=0 at snoopa 00..09, matching snoopd; then FSM=IDLE, busy=0.
- Readback: 02 00 03 after the load → out_data 03, 20, 60 in order, each held until out_ready; out_ready held low 5 cycles on the second byte → out_data=20 and snoopa stable throughout.
- Wrap/count-zero:
  - 01 FE 03 AA BB CC → writes at FE, FF, 00.
  - 01 10 00 followed by 256 bytes → last write at 0F, then IDLE.
- Run/halt: 03 → cpu_reset=0, snoopp=0 next cycle; then 02 05 01 → snoopp=1, cpu_reset=1 the cycle after 02, one byte returned; 04 → err clears.
- Errors: byte 7F in IDLE → err=1, no snoop write. With SNOOP_LOADER_CHECKSUM_EN, 01 00 01 55 then a wrong checksum 00 → write occurs, err=1.
- Reset mid-WRITE: assert reset after 01 00 04 AA → outputs at reset values; after release, 04 is parsed as HALT.
